hough_sweep_ctrl: RTL and testbench



---
 rtl/hough_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_hough_sweep_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hough_sweep_ctrl.sv
// hough_sweep_ctrl: sweeps line-stage m/c over a range, scores each candidate frame, keeps the best pair
module hough_sweep_ctrl #(
    parameter logic [7:0] M_MIN = 8'd0,
    parameter logic [7:0] M_MAX = 8'd7,
    parameter logic [7:0] C_MIN = 8'd0,
    parameter logic [7:0] C_MAX = 8'd15,
    parameter int SETTLE_FRAMES = 1,
    parameter int SCORE_W = 24
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic [7:0]         PixelIn,
    input  logic               FrameIn,
    input  logic               LineIn,
    output logic [7:0]         M,
    output logic [7:0]         C,
    output logic               Busy,
    output logic               Done,
    output logic [7:0]         BestM,
    output logic [7:0]         BestC,
    output logic [SCORE_W-1:0] BestScore
);
    typedef enum logic [2:0] {IDLE, SETTLE, WAIT_SOF, ACCUM, UPDATE, DONE} state_t;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);
    state_t state;
    logic frame_prev;
    logic [3:0] settle_cnt;
    logic [SCORE_W-1:0] score, score_sat;
    logic [SCORE_W:0] sum;
    logic sof, eof, valid, better, last;
    logic [7:0] win_m, win_c;
    always_comb begin
        sof = FrameIn & ~frame_prev;
        eof = ~FrameIn & frame_prev;
        valid = FrameIn & LineIn;
        sum = {1'b0, score} + (SCORE_W+1)'(PixelIn);
        score_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        better = score > BestScore;
        win_m = better ? M : BestM;
        win_c = better ? C : BestC;
        last = (M == M_MAX) && (C == C_MAX);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            frame_prev <= 1'b0;
            settle_cnt <= '0;
            score <= '0;
            M <= M_MIN;
            C <= C_MIN;
            Busy <= 1'b0;
            Done <= 1'b0;
            BestM <= M_MIN;
            BestC <= C_MIN;
            BestScore <= '0;
        end else begin
            frame_prev <= FrameIn;
            Done <= 1'b0;
            if (state != IDLE && Abort) begin
                state <= IDLE;
                settle_cnt <= '0;
                score <= '0;
                M <= M_MIN;
                C <= C_MIN;
                Busy <= 1'b0;
                BestM <= M_MIN;
                BestC <= C_MIN;
                BestScore <= '0;
            end else begin
                case (state)
                    IDLE: if (Start) begin
                        M <= M_MIN;
                        C <= C_MIN;
                        BestM <= M_MIN;
                        BestC <= C_MIN;
                        BestScore <= '0;
                        settle_cnt <= '0;
                        Busy <= 1'b1;
                        state <= SETTLE;
                    end
                    // a partial frame in flight when m/c changed still closes with an EOF that counts
                    SETTLE: if (eof) begin
                        settle_cnt <= settle_cnt + 4'd1;
                        state <= settle_cnt == SETTLE_LAST ? WAIT_SOF : SETTLE;
                    end
                    WAIT_SOF: if (sof) begin
                        score <= valid ? SCORE_W'(PixelIn) : '0;
                        state <= ACCUM;
                    end
                    ACCUM: begin
                        if (valid) score <= score_sat;
                        if (eof) state <= UPDATE;
                    end
                    UPDATE: begin
                        if (better) begin
                            BestScore <= score;
                            BestM <= M;
                            BestC <= C;
                        end
                        if (last) begin
                            M <= win_m;
                            C <= win_c;
                            Busy <= 1'b0;
                            Done <= 1'b1;
                            state <= DONE;
                        end else begin
                            C <= C == C_MAX ? C_MIN : C + 8'd1;
                            M <= C == C_MAX ? M + 8'd1 : M;
                            settle_cnt <= '0;
                            state <= SETTLE;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hough_sweep_ctrl.sv
// tb_hough_sweep_ctrl: sweeps three configurations over a synthetic 4x4 frame stream and checks the winners
module tb_hough_sweep_ctrl;
    localparam int HOT = 0, EQ = 1, RND = 2, GAP = 3;
    typedef struct {
        int k;
        int mode;
        int em;
        int ec;
        int es;
        int nc;
    } vec_t;

    logic Clk = 1'b0, Reset = 1'b1, FrameIn = 1'b0, LineIn = 1'b0;
    logic start[3], abort[3], busy[3], done[3];
    logic [7:0] px[3], m[3], c[3], bm[3], bc[3];
    logic [23:0] bs0, bs2;
    logic [7:0] bs1;
    logic [7:0] rtab[8][16][16];
    int n_tests = 0, n_fail = 0;
    int frame_no = 0, gap_idx = 0, pidx = 0, mode0 = HOT;
    bit in_frame = 0;
    int dcnt[3] = '{0, 0, 0}, chg[3] = '{0, 0, 0}, midchg[3] = '{0, 0, 0};
    logic [7:0] dm[3], dc[3], pm[3], pc[3];
    logic dbusy[3], pb[3];
    logic pframe = 1'b0;

    always #5 Clk = ~Clk;

    hough_sweep_ctrl dut0 (.Clk(Clk), .Reset(Reset), .Start(start[0]), .Abort(abort[0]), .PixelIn(px[0]),
        .FrameIn(FrameIn), .LineIn(LineIn), .M(m[0]), .C(c[0]), .Busy(busy[0]), .Done(done[0]),
        .BestM(bm[0]), .BestC(bc[0]), .BestScore(bs0));
    hough_sweep_ctrl #(.M_MAX(8'd0), .C_MAX(8'd3), .SCORE_W(8)) dut1 (.Clk(Clk), .Reset(Reset),
        .Start(start[1]), .Abort(abort[1]), .PixelIn(px[1]), .FrameIn(FrameIn), .LineIn(LineIn),
        .M(m[1]), .C(c[1]), .Busy(busy[1]), .Done(done[1]), .BestM(bm[1]), .BestC(bc[1]), .BestScore(bs1));
    hough_sweep_ctrl #(.M_MAX(8'd0), .C_MAX(8'd1), .SETTLE_FRAMES(2)) dut2 (.Clk(Clk), .Reset(Reset),
        .Start(start[2]), .Abort(abort[2]), .PixelIn(px[2]), .FrameIn(FrameIn), .LineIn(LineIn),
        .M(m[2]), .C(c[2]), .Busy(busy[2]), .Done(done[2]), .BestM(bm[2]), .BestC(bc[2]), .BestScore(bs2));

    function automatic logic [7:0] pix(int k, int md, logic [7:0] mm, logic [7:0] cc, int idx, int fno);
        if (k == 1) return cc == 8'd2 ? 8'hFF : 8'd1;
        if (k == 2) return 8'(fno);
        if (md == HOT) return (mm == 8'd3 && cc == 8'd5) ? 8'd9 : 8'd1;
        if (md == EQ) return 8'd2;
        return rtab[mm[2:0]][cc[3:0]][idx];
    endfunction

    // candidate i of the settle-2 config is scored on frame f0+2+3i
    function automatic void model(int k, int md, int f0, output int bmo, output int bco, output int bso);
        int mhi, chi, smax, s, i;
        mhi = k == 0 ? 7 : 0;
        chi = k == 0 ? 15 : k == 1 ? 3 : 1;
        smax = k == 1 ? 255 : 24'hFFFFFF;
        bmo = 0; bco = 0; bso = 0; i = 0;
        for (int mm = 0; mm <= mhi; mm++)
            for (int cc = 0; cc <= chi; cc++) begin
                s = 0;
                for (int p = 0; p < 16; p++) begin
                    s += int'(pix(k, md, 8'(mm), 8'(cc), p, f0 + 2 + 3 * i));
                    if (s > smax) s = smax;
                end
                if (s > bso) begin bso = s; bmo = mm; bco = cc; end
                i++;
            end
    endfunction

    function automatic logic [31:0] bsv(int k);
        return k == 0 ? 32'(bs0) : k == 1 ? 32'(bs1) : 32'(bs2);
    endfunction

    task automatic drive(bit v, int idx);
        for (int k = 0; k < 3; k++) px[k] = v ? pix(k, mode0, m[k], c[k], idx, frame_no) : 8'($urandom);
    endtask

    // frame stream: GAP idle cycles, then 4 lines of 4 pixels + 1 blank cycle each
    initial forever begin
        for (int g = 0; g < GAP; g++) begin
            @(negedge Clk);
            FrameIn = 1'b0; LineIn = 1'($urandom); in_frame = 0; gap_idx = g;
            drive(0, 0);
        end
        frame_no++;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            FrameIn = 1'b1; in_frame = 1; gap_idx = -1;
            LineIn = (i % 5) < 4; pidx = (i / 5) * 4 + i % 5;
            drive(LineIn, pidx);
        end
    end

    always begin
        @(posedge Clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) begin dcnt[k]++; dm[k] = m[k]; dc[k] = c[k]; dbusy[k] = busy[k]; end
            if (busy[k] && pb[k] && (m[k] != pm[k] || c[k] != pc[k])) begin
                chg[k]++;
                if (FrameIn && pframe) midchg[k]++;
            end
            pm[k] = m[k]; pc[k] = c[k]; pb[k] = busy[k];
        end
        pframe = FrameIn;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(int k, int d0, int budget);
        int t = 0;
        while (dcnt[k] == d0 && t < budget) begin tick(); t++; end
        chk($sformatf("sweep%0d_finished", k), 32'(dcnt[k] != d0), 1);
    endtask

    task automatic wait_eof(int budget);
        int pg, t;
        bit found;
        pg = gap_idx; t = 0; found = 0;
        while (!found && t < budget) begin
            tick(); t++;
            found = gap_idx == 0 && pg != 0;
            pg = gap_idx;
        end
        chk("eof_seen", 32'(found), 1);
    endtask

    task automatic chk_reset0(string tag);
        chk({tag, "_M"}, 32'(m[0]), 0);
        chk({tag, "_C"}, 32'(c[0]), 0);
        chk({tag, "_Busy"}, 32'(busy[0]), 0);
        chk({tag, "_Done"}, 32'(done[0]), 0);
        chk({tag, "_BestM"}, 32'(bm[0]), 0);
        chk({tag, "_BestC"}, 32'(bc[0]), 0);
        chk({tag, "_BestScore"}, 32'(bs0), 0);
    endtask

    initial begin
        vec_t vt[4];
        int em, ec, es, k, d0, c0, t, f0;
        for (int i = 0; i < 3; i++) begin start[i] = 1'b0; abort[i] = 1'b0; end
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 16; b++) begin
                bit z;
                z = $urandom_range(0, 3) == 0;
                for (int p = 0; p < 16; p++) rtab[a][b][p] = z ? 8'd0 : 8'($urandom_range(0, 15));
            end
        model(0, RND, 0, em, ec, es);
        vt[0] = '{0, HOT, 3, 5, 144, 128};
        vt[1] = '{0, EQ, 0, 0, 32, 128};
        vt[2] = '{0, RND, em, ec, es, 128};
        vt[3] = '{1, HOT, 0, 2, 255, 4};

        repeat (3) tick();
        chk_reset0("reset");
        Reset = 1'b0;
        tick();

        // abort during the scored frame of candidate (2,7)
        mode0 = EQ; d0 = dcnt[0];
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        t = 0;
        while (!(m[0] == 8'd2 && c[0] == 8'd7) && t < 9000) begin tick(); t++; end
        chk("abort_reach_2_7", 32'(t < 9000), 1);
        wait_eof(200);
        t = 0;
        while (!(in_frame && pidx >= 5) && t < 100) begin tick(); t++; end
        chk("abort_busy_before", 32'(busy[0]), 1);
        chk("abort_best_before", bsv(0), 32);
        abort[0] = 1'b1; tick(); abort[0] = 1'b0;
        chk_reset0("abort");
        repeat (300) tick();
        chk("abort_no_done", 32'(dcnt[0] - d0), 0);
        chk("abort_stays_idle", 32'(busy[0]), 0);

        for (int i = 0; i < 4; i++) begin
            k = vt[i].k; mode0 = vt[i].mode; d0 = dcnt[k]; c0 = chg[k];
            start[k] = 1'b1; tick(); start[k] = 1'b0;
            chk($sformatf("v%0d_busy", i), 32'(busy[k]), 1);
            wait_done(k, d0, 9000);
            repeat (30) tick();
            chk($sformatf("v%0d_done_once", i), 32'(dcnt[k] - d0), 1);
            chk($sformatf("v%0d_candidates", i), 32'(chg[k] - c0 + 1), 32'(vt[i].nc));
            chk($sformatf("v%0d_BestM", i), 32'(bm[k]), 32'(vt[i].em));
            chk($sformatf("v%0d_BestC", i), 32'(bc[k]), 32'(vt[i].ec));
            chk($sformatf("v%0d_BestScore", i), bsv(k), 32'(vt[i].es));
            chk($sformatf("v%0d_M_at_done", i), 32'(dm[k]), 32'(vt[i].em));
            chk($sformatf("v%0d_C_at_done", i), 32'(dc[k]), 32'(vt[i].ec));
            chk($sformatf("v%0d_busy_at_done", i), 32'(dbusy[k]), 0);
            chk($sformatf("v%0d_M_held", i), 32'(m[k]), 32'(vt[i].em));
            chk($sformatf("v%0d_idle", i), 32'(busy[k]), 0);
        end

        // settle-2 config started mid-frame: partial frame EOF counts, one full frame dropped
        t = 0;
        while (!(in_frame && pidx == 5) && t < 100) begin tick(); t++; end
        f0 = frame_no; d0 = dcnt[2]; c0 = midchg[2];
        start[2] = 1'b1; tick(); start[2] = 1'b0;
        wait_done(2, d0, 1000);
        repeat (5) tick();
        model(2, HOT, f0, em, ec, es);
        chk("settle2_BestScore", bsv(2), 32'(es));
        chk("settle2_BestC", 32'(bc[2]), 32'(ec));
        chk("settle2_done_once", 32'(dcnt[2] - d0), 1);
        chk("settle2_no_midframe_change", 32'(midchg[2] - c0), 0);

        // Start while busy is ignored; Reset during UPDATE clears everything
        mode0 = HOT; d0 = dcnt[0];
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        t = 0;
        while (c[0] == 8'd0 && t < 200) begin tick(); t++; end
        chk("rst_first_advance", 32'(c[0]), 1);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        chk("busy_start_ignored_C", 32'(c[0]), 1);
        chk("busy_start_ignored_Busy", 32'(busy[0]), 1);
        wait_eof(200);
        wait_eof(200);
        chk("rst_best_before", bsv(0), 16);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk_reset0("midreset");
        repeat (200) tick();
        chk("midreset_no_done", 32'(dcnt[0] - d0), 0);
        chk("midreset_idle", 32'(busy[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
